// File: rtl/stopwatch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_pkg
// Shared definitions for the stopwatch control block:
//   - state_t        : control state encoding (IDLE=0, RUN=1, PAUSED=2),
//                      also driven straight onto state_o for LED indication
//   - DB_CYC_DEFAULT : default debounce length (10 ms at 100 MHz)
//   - BTN_START/CLR  : index of each button inside the debouncer bank
// -----------------------------------------------------------------------------
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    localparam int DB_CYC_DEFAULT = 1000000;

    localparam int BTN_START = 0;
    localparam int BTN_CLR   = 1;
    localparam int NUM_BTN   = 2;

endpackage : stopwatch_ctrl_pkg

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Synchronizes one raw push-button, debounces it and emits a one-cycle press
// pulse on each debounced 0->1 transition (releases give no pulse).
//
// Ports:
//   clk_i   in  system clock, rising edge
//   rst_i   in  synchronous active-high reset
//   btn_i   in  raw asynchronous button level, high = pressed
//   press_o out registered one-cycle press pulse
//
// Latency: press_o is high exactly DB_CYC+2 edges after the first edge that
// samples btn_i high (2 sync stages, DB_CYC differing cycles, 1 edge-detect).
// -----------------------------------------------------------------------------
module button_debouncer
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DB_CYC = DB_CYC_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int              CW       = $clog2(DB_CYC + 1);
    // The stable level flips on the DB_CYC-th consecutive differing cycle, so
    // the counter never needs to hold more than DB_CYC-1 and cannot wrap.
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stable_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= btn_i;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            // Rising edge of the debounced level only.
            r_press    <= r_stable & ~r_stable_d;

            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign press_o = r_press;

endmodule : button_debouncer

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Start/stop/clear control for a BCD stopwatch counter. Two debounced buttons
// drive an IDLE/RUN/PAUSED state machine with fully registered outputs.
//
// Ports:
//   clk_i        in   system clock, rising edge
//   rst_i        in   synchronous active-high reset
//   btn_start_i  in   raw start/stop button, high = pressed
//   btn_clr_i    in   raw clear button, high = pressed
//   run_o        out  counter enable, high only in RUN
//   clr_o        out  one-cycle counter clear pulse on every clear press
//   state_o      out  current state (IDLE=0, RUN=1, PAUSED=2)
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DB_CYC = DB_CYC_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_start_i,
    input  logic       btn_clr_i,
    output logic       run_o,
    output logic       clr_o,
    output logic [1:0] state_o
);

    logic [NUM_BTN-1:0] w_btn_raw;
    logic [NUM_BTN-1:0] w_press;

    assign w_btn_raw[BTN_START] = btn_start_i;
    assign w_btn_raw[BTN_CLR]   = btn_clr_i;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
            button_debouncer #(
                .DB_CYC (DB_CYC)
            ) u_db (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .btn_i   (w_btn_raw[gi]),
                .press_o (w_press[gi])
            );
        end
    endgenerate

    state_t r_state;
    logic   r_run;
    logic   r_clr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_clr <= 1'b0;
            // Clear has priority over a start press landing in the same cycle,
            // and pulses clr_o even when already idle.
            if (w_press[BTN_CLR]) begin
                r_state <= ST_IDLE;
                r_run   <= 1'b0;
                r_clr   <= 1'b1;
            end else if (w_press[BTN_START]) begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_RUN;
                        r_run   <= 1'b1;
                    end
                    ST_RUN: begin
                        r_state <= ST_PAUSED;
                        r_run   <= 1'b0;
                    end
                    ST_PAUSED: begin
                        r_state <= ST_RUN;
                        r_run   <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_run   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign run_o   = r_run;
    assign clr_o   = r_clr;
    assign state_o = r_state;

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Self-checking bench for stopwatch_ctrl with DB_CYC=4. A behavioural model
// (delay line + sliding window of the last DB samples + state table) predicts
// run_o/clr_o/state_o every cycle; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int DB = 4;

    logic       clk;
    logic       rst;
    logic       btn_start;
    logic       btn_clr;
    logic       run;
    logic       clr;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    stopwatch_ctrl #(
        .DB_CYC (DB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_start_i (btn_start),
        .btn_clr_i   (btn_clr),
        .run_o       (run),
        .clr_o       (clr),
        .state_o     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Index 0 = start button, 1 = clear button.
    // A button's debounced level toggles once the last DB values seen after
    // the two-stage synchronizer all differ from it; a press is reported the
    // cycle after a rising toggle becomes visible.
    // ------------------------------------------------------------------
    bit m_dl0   [2];
    bit m_dl1   [2];
    bit m_win   [2][DB];
    bit m_stable[2];
    bit m_rise  [2];
    bit m_pulse [2];
    int m_state;
    int m_run;
    int m_clr;

    always @(posedge clk) begin
        bit raw [2];
        bit seen;
        bit all_diff;
        raw[0] = btn_start;
        raw[1] = btn_clr;

        // Control decision uses the press pulses visible before this edge.
        if (rst) begin
            m_state = 0;
            m_clr   = 0;
        end else begin
            m_clr = 0;
            if (m_pulse[1]) begin
                m_state = 0;
                m_clr   = 1;
            end else if (m_pulse[0]) begin
                m_state = (m_state == 1) ? 2 : 1;
            end
        end
        m_run = (m_state == 1) ? 1 : 0;

        for (int b = 0; b < 2; b++) begin
            if (rst) begin
                m_dl0[b]    = 0;
                m_dl1[b]    = 0;
                m_stable[b] = 0;
                m_rise[b]   = 0;
                m_pulse[b]  = 0;
                for (int k = 0; k < DB; k++) m_win[b][k] = 0;
            end else begin
                seen     = m_dl1[b];
                m_dl1[b] = m_dl0[b];
                m_dl0[b] = raw[b];
                for (int k = DB - 1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
                m_win[b][0] = seen;
                m_pulse[b]  = m_rise[b];
                all_diff = 1;
                for (int k = 0; k < DB; k++)
                    if (m_win[b][k] == m_stable[b]) all_diff = 0;
                m_rise[b] = 0;
                if (all_diff) begin
                    m_stable[b] = !m_stable[b];
                    m_rise[b]   = m_stable[b];
                end
            end
        end
        started = 1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("model_state", int'(state), m_state);
            check("model_run",   int'(run),   m_run);
            check("model_clr",   int'(clr),   m_clr);
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: hold DB+4 cycles (outputs update DB+3 edges after press),
    // then release long enough for the debounced level to return low.
    task automatic clean_press(input bit s, input bit c);
        btn_start = s;
        btn_clr   = c;
        wait_neg(DB + 4);
        btn_start = 0;
        btn_clr   = 0;
        wait_neg(DB + 4);
    endtask

    initial begin
        int hold_s;
        int hold_c;
        rst       = 1;
        btn_start = 0;
        btn_clr   = 0;
        wait_neg(3);

        // Reset values.
        check("reset_state", int'(state), 0);
        check("reset_run",   int'(run),   0);
        check("reset_clr",   int'(clr),   0);
        $display("step reset: state=%0d run=%0d clr=%0d", state, run, clr);

        // Start held from reset release: pulse at edge 6, outputs at edge 7.
        rst       = 0;
        btn_start = 1;
        wait_neg(7);
        check("hold_before_edge7_state", int'(state), 0);
        wait_neg(1);
        check("hold_edge7_state", int'(state), 1);
        check("hold_edge7_run",   int'(run),   1);
        wait_neg(12);
        check("hold_20cyc_state", int'(state), 1);
        btn_start = 0;
        wait_neg(10);
        check("release_no_change", int'(state), 1);
        $display("step held_start: state=%0d run=%0d", state, run);

        // Short glitches never reach the debounce length.
        rst = 1;
        wait_neg(2);
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            btn_start = 1;
            wait_neg(3);
            btn_start = 0;
            wait_neg(1);
        end
        wait_neg(10);
        check("glitch_state", int'(state), 0);
        check("glitch_run",   int'(run),   0);
        $display("step glitch: state=%0d run=%0d", state, run);

        // Three clean start presses: RUN, PAUSED, RUN.
        clean_press(1, 0);
        check("press1_state", int'(state), 1);
        check("press1_run",   int'(run),   1);
        clean_press(1, 0);
        check("press2_state", int'(state), 2);
        check("press2_run",   int'(run),   0);
        clean_press(1, 0);
        check("press3_state", int'(state), 1);
        check("press3_run",   int'(run),   1);
        $display("step three_presses: state=%0d run=%0d", state, run);

        // Start and clear together while running: clear wins.
        btn_start = 1;
        btn_clr   = 1;
        wait_neg(DB + 3);
        check("both_pre_state", int'(state), 1);
        wait_neg(1);
        check("both_state", int'(state), 0);
        check("both_run",   int'(run),   0);
        check("both_clr",   int'(clr),   1);
        wait_neg(1);
        check("both_clr_one_cycle", int'(clr), 0);
        btn_start = 0;
        btn_clr   = 0;
        wait_neg(DB + 4);
        $display("step start_and_clear: state=%0d clr=%0d", state, clr);

        // Clear while already idle still pulses clr_o.
        btn_clr = 1;
        wait_neg(DB + 4);
        check("idle_clr_pulse", int'(clr), 1);
        btn_clr = 0;
        wait_neg(DB + 4);

        // Reset in the middle of a start debounce while running.
        clean_press(1, 0);
        check("pre_reset_run", int'(run), 1);
        btn_start = 1;
        wait_neg(3);
        rst = 1;
        wait_neg(1);
        check("midrst_state", int'(state), 0);
        check("midrst_run",   int'(run),   0);
        check("midrst_clr",   int'(clr),   0);
        rst = 0;
        wait_neg(2);
        btn_start = 0;
        for (int i = 0; i < 12; i++) begin
            wait_neg(1);
            check("midrst_no_pulse_state", int'(state), 0);
            check("midrst_no_pulse_clr",   int'(clr),   0);
        end
        $display("step mid_debounce_reset: state=%0d run=%0d", state, run);

        // Randomized phase, checked by the per-cycle model comparison.
        hold_s = 0;
        hold_c = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_s == 0) begin
                btn_start = 1'($urandom_range(0, 1));
                hold_s    = int'($urandom_range(1, 10));
            end
            if (hold_c == 0) begin
                btn_clr = ($urandom_range(0, 3) == 0);
                hold_c  = int'($urandom_range(1, 10));
            end
            hold_s--;
            hold_c--;
            rst = ($urandom_range(0, 299) == 0);
            wait_neg(1);
        end
        rst = 0;
        wait_neg(2);
        $display("step random: done, state=%0d", state);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stopwatch_ctrl

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001: Parameter DB_CYC, default 1000000, debounce length in clk_i cycles (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-002: clk_i  input  1  single system clock, rising edge.
REQ-003: rst_i  input  1  synchronous, active-high reset.
REQ-004: btn_start_i  input  1  raw asynchronous start/stop push-button, high = pressed.
REQ-005: btn_clr_i  input  1  raw asynchronous clear push-button, high = pressed.
REQ-006: run_o  output  1  counter enable for the downstream BCD counter, high = counting.
REQ-007: clr_o  output  1  one-cycle counter-clear pulse for the downstream BCD counter.
REQ-008: state_o  output  2  current control state (IDLE=0, RUN=1, PAUSED=2) for LED indication.

Function
REQ-009: Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010: Each synchronized button SHALL be debounced: a stable level register plus a counter that clears whenever the synchronized level equals the stable level.
REQ-011: The stable level SHALL flip only after the synchronized level has differed from it for DB_CYC consecutive cycles; any shorter excursion SHALL leave it unchanged and clear the counter.
REQ-012: Each debouncer SHALL produce a registered one-cycle press pulse on a 0->1 transition of the stable level only; releases SHALL produce no pulse.
REQ-013: A button held high indefinitely SHALL produce exactly one press pulse.
REQ-014: Press pulse SHALL assert exactly DB_CYC+2 rising edges after the first edge that samples the raw input high, provided the input stays high throughout.
REQ-015: FSM states: IDLE, RUN, PAUSED; all outputs registered and updated on the edge after the press pulse (DB_CYC+3 edges after raw press).
REQ-016: Start press: IDLE->RUN, RUN->PAUSED, PAUSED->RUN.
REQ-017: Clear press in any state: go to IDLE and assert clr_o for exactly one cycle.
REQ-018: Simultaneous start and clear press pulses in the same cycle: clear wins; go to IDLE, pulse clr_o, ignore start.
REQ-019: run_o SHALL be 1 only in RUN; state_o SHALL encode the current state per REQ-008.
REQ-020: Clear pulse while already IDLE SHALL still emit the clr_o pulse.
REQ-021: Debounce counter SHALL be ceil(log2(DB_CYC+1)) bits wide and SHALL never wrap.

Reset
REQ-022: While rst_i is high at a clock edge, synchronizers, stable levels and counters SHALL clear to 0, and the FSM SHALL enter IDLE.
REQ-023: Reset values: run_o=0, clr_o=0, state_o=0; reset SHALL NOT generate a clr_o pulse.
REQ-024: A button already held at reset release SHALL produce a press pulse per REQ-014 counted from the first post-reset edge.
REQ-025: Reset asserted mid-debounce or mid-RUN SHALL abort immediately; no pending pulse SHALL survive it.

Structure
REQ-026: A shared package SHALL hold the state encoding (IDLE/RUN/PAUSED) and the DB_CYC default constant.
REQ-027: Synchronizer + debouncer + press-edge logic SHALL be one sub-module, button_debouncer, instantiated twice; the FSM SHALL be in stopwatch_ctrl.

Verification (DB_CYC=4)
REQ-028: Reset, then start held high 20 cycles -> single press pulse at edge 6; run_o=1, state_o=1 from edge 7; no further change.
REQ-029: Start glitches high for 3 cycles, repeated 5 times with 1-cycle gaps -> no pulse, run_o stays 0.
REQ-030: Three clean start presses -> state_o sequence 1, 2, 1; run_o 1, 0, 1.
REQ-031: In RUN, start and clear pressed on the same edge -> state_o=0, run_o=0, clr_o high exactly one cycle.
REQ-032: In RUN, rst_i pulsed for one cycle during a start debounce count -> state_o=0, run_o=0, clr_o=0, no press pulse from the interrupted count.
